// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq: sequential unsigned shift-and-add multiplier.
// A single WIDTH-bit adder (with carry-out) is reused for WIDTH steps,
// consuming one multiplier bit per step from the low half of the
// accumulator. The product is held until the next accepted start.
module shift_add_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Counter width: enough range for WIDTH-1, at least one bit.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [WIDTH-1:0]       mcand_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [CW-1:0]          cnt_r;

  logic [WIDTH-1:0]       hi_s;
  logic [WIDTH-1:0]       lo_s;
  logic [WIDTH-1:0]       addend_s;
  logic [WIDTH:0]         sum_s;
  logic [2*WIDTH-1:0]     acc_shift_s;
  logic                   accept_s;
  logic                   last_s;

  assign hi_s     = acc_r[2*WIDTH-1:WIDTH];
  assign lo_s     = acc_r[WIDTH-1:0];
  assign accept_s = (state_r == ST_IDLE) && start;
  assign last_s   = (cnt_r == CNT_LAST);

  // Shared adder: add the multiplicand to the high half when the current
  // multiplier bit is set, then shift the (2W+1)-bit result right by one
  // so the carry-out lands in the MSB of the accumulator.
  always_comb begin
    addend_s    = {WIDTH{1'b0}};
    sum_s       = {(WIDTH+1){1'b0}};
    acc_shift_s = {(2*WIDTH){1'b0}};
    if (acc_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s       = {1'b0, hi_s} + {1'b0, addend_s};
    acc_shift_s = {sum_s, lo_s[WIDTH-1:1]};
  end

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH steps, one DONE cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, step the accumulator while running;
  // the accumulator is left untouched in DONE and IDLE so product holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      mcand_r <= a;
      acc_r   <= {{WIDTH{1'b0}}, b};
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      acc_r   <= acc_shift_s;
      cnt_r   <= cnt_r + CNT_ONE;
    end else begin
      mcand_r <= mcand_r;
      acc_r   <= acc_r;
      cnt_r   <= cnt_r;
    end
  end

  // Status flags are pure decodes of the state register.
  assign ready   = (state_r == ST_IDLE);
  assign busy    = (state_r == ST_RUN);
  assign done    = (state_r == ST_DONE);
  assign product = acc_r;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Bench for shift_add_mult_seq at WIDTH=8 (directed), WIDTH=2 (exhaustive)
// and WIDTH=16 (corners plus random). Expected products are queued when a
// start is issued and popped by per-instance monitors on done.
module tb_shift_add_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- WIDTH=8 instance ----------------
  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        ready8, busy8, done8;
  logic [15:0] product8;
  logic [15:0] q8[$];

  shift_add_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  // ---------------- WIDTH=2 instance ----------------
  logic        start2 = 1'b0;
  logic [1:0]  a2 = 2'd0, b2 = 2'd0;
  logic        ready2, busy2, done2;
  logic [3:0]  product2;
  logic [3:0]  q2[$];

  shift_add_mult_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .busy(busy2), .done(done2), .product(product2)
  );

  // ---------------- WIDTH=16 instance ----------------
  logic        start16 = 1'b0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic        ready16, busy16, done16;
  logic [31:0] product16;
  logic [31:0] q16[$];

  shift_add_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16)
  );

  // Monitors: one-hot status and scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot8", 64'($countones({ready8, busy8, done8})), 64'd1);
      if (done8) begin
        if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
        else check("product8", 64'(product8), 64'(q8.pop_front()));
      end
      if (done2) begin
        if (q2.size() == 0) check("unexpected_done2", 64'd1, 64'd0);
        else check("product2", 64'(product2), 64'(q2.pop_front()));
      end
      if (done16) begin
        if (q16.size() == 0) check("unexpected_done16", 64'd1, 64'd0);
        else check("product16", 64'(product16), 64'(q16.pop_front()));
      end
    end
  end

  task automatic wait_ready8();
    int k = 0;
    @(negedge clk);
    while (!ready8 && k < 100) begin @(negedge clk); k++; end
    if (!ready8) check("ready8_timeout", 64'd0, 64'd1);
  endtask

  // Issue one WIDTH=8 operation, check busy length and return to ready.
  // With interfere set, a start with other operands is pulsed mid-RUN.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit interfere);
    int nb = 0;
    int k = 0;
    logic [15:0] e;
    e = {8'd0, x} * {8'd0, y};
    wait_ready8();
    a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    @(negedge clk);
    while (!done8 && k < 40) begin
      if (busy8) nb++;
      if (interfere && nb == 3) begin
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    check("done8_seen", 64'(done8), 64'd1);
    check("busy8_cycles", 64'(nb), 64'd8);
    @(negedge clk);
    check("ready8_after_done", 64'(ready8), 64'd1);
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y);
    int k = 0;
    @(negedge clk);
    while (!ready2 && k < 50) begin @(negedge clk); k++; end
    a2 = x; b2 = y; start2 = 1'b1;
    q2.push_back({2'd0, x} * {2'd0, y});
    @(posedge clk);
    #1 start2 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done2 && k < 20) begin @(negedge clk); k++; end
    if (!done2) check("done2_timeout", 64'd0, 64'd1);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y);
    int k = 0;
    @(negedge clk);
    while (!ready16 && k < 50) begin @(negedge clk); k++; end
    a16 = x; b16 = y; start16 = 1'b1;
    q16.push_back({16'd0, x} * {16'd0, y});
    @(posedge clk);
    #1 start16 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done16 && k < 40) begin @(negedge clk); k++; end
    if (!done16) check("done16_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc_cyc[3];
    logic [7:0] ha[3];
    logic [7:0] hb[3];
    int k;

    // Reset state, before any clock edge.
    #1;
    check("rst_ready", 64'(ready8), 64'd1);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_product", 64'(product8), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors.
    op8(8'd13, 8'd11, 1'b0);
    op8(8'd255, 8'd255, 1'b0);
    op8(8'd0, 8'd200, 1'b0);
    op8(8'd200, 8'd0, 1'b0);
    op8(8'd13, 8'd11, 1'b1);
    repeat (12) @(negedge clk);   // any second done would be flagged

    // Reset during the 4th RUN cycle discards the operation.
    wait_ready8();
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready8), 64'd1);
    check("midrst_busy", 64'(busy8), 64'd0);
    check("midrst_done", 64'(done8), 64'd0);
    check("midrst_product", 64'(product8), 64'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    op8(8'd7, 8'd9, 1'b0);

    // Start held high: a new operation at every IDLE cycle.
    ha[0] = 8'd1; hb[0] = 8'd1;
    ha[1] = 8'd2; hb[1] = 8'd3;
    ha[2] = 8'd255; hb[2] = 8'd2;
    for (int i = 0; i < 3; i++) begin
      wait_ready8();
      a8 = ha[i]; b8 = hb[i]; start8 = 1'b1;
      q8.push_back({8'd0, ha[i]} * {8'd0, hb[i]});
      @(posedge clk);
      acc_cyc[i] = cyc;
      #1;
      if (i == 2) start8 = 1'b0;
    end
    check("held_period_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
    check("held_period_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd10);
    k = 0;
    while (q8.size() != 0 && k < 40) begin @(negedge clk); k++; end
    check("q8_drained", 64'(q8.size()), 64'd0);

    // WIDTH=2 exhaustive.
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        op2(2'(x), 2'(y));

    // WIDTH=16 corners and random.
    op16(16'hFFFF, 16'hFFFF);
    op16(16'h0000, 16'h1234);
    op16(16'h8001, 16'h0002);
    for (int i = 0; i < 20; i++) op16(16'($urandom), 16'($urandom));

    repeat (4) @(negedge clk);
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
